universal_shift_reg: RTL

// - Parametrised successor to the 4-bit PIPO register: WIDTH-bit register with parallel load,

---
 rtl/usr_pkg.sv | 14 +
 rtl/usr_shift_step.sv | 27 ++
 rtl/universal_shift_reg.sv | 96 +++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: the shift/rotate mode codes and the FSM state encoding.
package usr_pkg;

  localparam logic [1:0] MODE_SHL = 2'b00;
  localparam logic [1:0] MODE_SHR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/usr_shift_step.sv
// Single-bit shift/rotate step: computes the next register value for one shift cycle.
// Latency: combinational, zero cycles.
// Backpressure: none; this is a pure function of its inputs.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cur,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (mode)
      MODE_SHL: nxt = {cur[WIDTH-2:0], s_in_r};
      MODE_SHR: nxt = {s_in_l, cur[WIDTH-1:1]};
      MODE_ROL: nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR: nxt = {cur[0], cur[WIDTH-1:1]};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with parallel load and multi-cycle shift/rotate commands, one bit per cycle.
// Latency: load in one edge; a start with amount N completes after N edges, done pulses the cycle after.
// Backpressure: load/start are ignored while busy; nothing is queued.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             s_in_r,
  input  logic             s_in_l,
  output logic [WIDTH-1:0] p_out,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .mode   (mode_q),
    .cur    (reg_q),
    .s_in_l (s_in_l),
    .s_in_r (s_in_r),
    .nxt    (step_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    reg_d   = reg_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          reg_d = p_in;
        end else if (start) begin
          // A zero-length command completes immediately without entering SHIFT.
          if (amount != '0) begin
            mode_d  = mode;
            cnt_d   = amount;
            state_d = ST_SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        reg_d = step_val;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_SHL;
      reg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      reg_q   <= reg_d;
      done_q  <= done_d;
    end
  end

  assign p_out   = reg_q;
  assign s_out_l = reg_q[WIDTH-1];
  assign s_out_r = reg_q[0];
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;

endmodule
